// File: rtl/seg_s2p.sv
// Serial-to-parallel frame receiver: synchronizes an asynchronous shift clock,
// data and strobes into clk, assembles MSB-first frames and commits them on EN.
module seg_s2p #(
    parameter int DATA_BITS   = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_clk,
    input  logic                 sin,
    input  logic                 EN,
    input  logic                 s_clrn,
    output logic [DATA_BITS-1:0] P_Data,
    output logic                 valid,
    output logic                 busy,
    output logic [6:0]           bit_cnt,
    output logic                 err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [6:0] CNT_FULL = 7'(DATA_BITS);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] sin_sync_q;
    logic [SYNC_STAGES-1:0] en_sync_q;
    logic [SYNC_STAGES-1:0] clrn_sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   sclk_hist_q;
    logic                   en_hist_q;
    logic                   armed_q;

    logic [1:0]           state_q, state_d;
    logic [6:0]           cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] pdata_q, pdata_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 busy_q;

    logic sclk_rise_s;
    logic en_rise_s;
    logic clr_s;
    logic sin_s;

    // Synchronizers, edge history and the s_clk arming flag.
    // fill_q tracks when the chain holds real pin samples; armed_q then waits
    // for s_clk low so a clock already high at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            sin_sync_q  <= '0;
            en_sync_q   <= '0;
            clrn_sync_q <= '0;
            fill_q      <= '0;
            sclk_hist_q <= 1'b0;
            en_hist_q   <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], s_clk};
            sin_sync_q  <= {sin_sync_q[SYNC_STAGES-2:0], sin};
            en_sync_q   <= {en_sync_q[SYNC_STAGES-2:0], EN};
            clrn_sync_q <= {clrn_sync_q[SYNC_STAGES-2:0], s_clrn};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
            en_hist_q   <= en_sync_q[SYNC_STAGES-1];
            armed_q     <= armed_q | (fill_q[SYNC_STAGES-1] & ~sclk_sync_q[SYNC_STAGES-1]);
        end
    end

    assign sclk_rise_s = sclk_sync_q[SYNC_STAGES-1] & ~sclk_hist_q & armed_q;
    assign en_rise_s   = en_sync_q[SYNC_STAGES-1] & ~en_hist_q;
    assign clr_s       = ~clrn_sync_q[SYNC_STAGES-1];
    assign sin_s       = sin_sync_q[SYNC_STAGES-1];

    // Frame FSM: clear beats EN, EN beats s_clk; lower events that cycle are dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        pdata_d = pdata_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (clr_s) begin
            shreg_d = '0;
            cnt_d   = 7'd0;
            state_d = ST_IDLE;
        end else if (en_rise_s) begin
            case (state_q)
                ST_FULL: begin
                    pdata_d = shreg_q;
                    valid_d = 1'b1;
                end
                default: begin
                    err_d = 1'b1;
                end
            endcase
            shreg_d = '0;
            cnt_d   = 7'd0;
            state_d = ST_IDLE;
        end else if (sclk_rise_s) begin
            shreg_d = {shreg_q[DATA_BITS-2:0], sin_s};
            case (state_q)
                ST_FULL: begin
                    err_d = 1'b1;
                end
                default: begin
                    cnt_d   = cnt_q + 7'd1;
                    state_d = (cnt_d == CNT_FULL) ? ST_FULL : ST_SHIFT;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 7'd0;
            shreg_q <= '0;
            pdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            pdata_q <= pdata_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign P_Data  = pdata_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_seg_s2p.sv
// Bench for seg_s2p: table of frames plus hand sequences for coincident
// EN/s_clk and reset mid-frame; pulses are matched against a queue of expectations.
module tb_seg_s2p;

    logic        clk;
    logic        rst;
    logic        s_clk;
    logic        sin;
    logic        EN;
    logic        s_clrn;
    logic [63:0] P_Data;
    logic        valid;
    logic        busy;
    logic [6:0]  bit_cnt;
    logic        err;

    seg_s2p dut (
        .clk     (clk),
        .rst     (rst),
        .s_clk   (s_clk),
        .sin     (sin),
        .EN      (EN),
        .s_clrn  (s_clrn),
        .P_Data  (P_Data),
        .valid   (valid),
        .busy    (busy),
        .bit_cnt (bit_cnt),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_valid;
        logic [63:0] data;
    } exp_t;

    typedef struct {
        logic [65:0] bits;
        int          nbits;
        int          clrn_after;
        int          n_ovr;
        int          exp_cnt;
        logic        exp_valid;
        logic [63:0] exp_data;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        vecs[7];
    logic [63:0] pdata_model;
    int          checks;
    int          errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One clk cycle, sampled on the falling edge; every pulse is matched to the queue.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (valid || err) begin
            checks++;
            if (valid && err) begin
                errors++;
                $display("FAIL both_pulses valid=%0b err=%0b required=not both", valid, err);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse valid=%0b err=%0b required=no pulse", valid, err);
            end else begin
                e = exp_q.pop_front();
                if (valid !== e.is_valid) begin
                    errors++;
                    $display("FAIL pulse_kind valid=%0b err=%0b required_valid=%0b", valid, err, e.is_valid);
                end
                if (e.is_valid) pdata_model = e.data;
            end
        end
        checks++;
        if (P_Data !== pdata_model) begin
            errors++;
            $display("FAIL p_data actual=%h required=%h", P_Data, pdata_model);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_bit(input logic b);
        s_clk = 1'b0;
        sin   = b;
        ticks(4);
        s_clk = 1'b1;
        ticks(4);
    endtask

    task automatic send_word(input logic [63:0] w);
        for (int b = 63; b >= 0; b--) send_bit(w[b]);
    endtask

    task automatic push(input logic is_valid, input logic [63:0] data);
        exp_t e;
        e.is_valid = is_valid;
        e.data     = data;
        exp_q.push_back(e);
    endtask

    task automatic en_pulse();
        EN = 1'b1;
        ticks(4);
        EN = 1'b0;
        ticks(4);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_cnt"}, 64'(bit_cnt), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        vec_t v;
        checks      = 0;
        errors      = 0;
        pdata_model = 64'd0;
        rst    = 1'b1;
        s_clk  = 1'b0;
        sin    = 1'b0;
        EN     = 1'b0;
        s_clrn = 1'b1;

        vecs[0] = '{66'h0123456789ABCDEF, 64, 0, 0, 64, 1'b1, 64'h0123456789ABCDEF};
        vecs[1] = '{66'h00A5A5F00F0F, 40, 0, 0, 40, 1'b0, 64'h0};
        vecs[2] = '{66'h3FEDCBA9876543210, 66, 0, 2, 64, 1'b1, 64'hFEDCBA9876543210};
        vecs[3] = '{66'hDEADBEEFCAFEF00D, 64, 30, 0, 64, 1'b1, 64'hDEADBEEFCAFEF00D};
        vecs[4] = '{66'h8000000000000001, 64, 0, 0, 64, 1'b1, 64'h8000000000000001};
        vecs[5] = '{66'hFFFFFFFFFFFFFFFF, 64, 0, 0, 64, 1'b1, 64'hFFFFFFFFFFFFFFFF};
        vecs[6] = '{66'h0, 64, 0, 0, 64, 1'b1, 64'h0};

        ticks(3);
        chk("reset_pdata", P_Data, 64'd0);
        chk("reset_valid", 64'(valid), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        chk_idle("reset");
        rst = 1'b0;
        ticks(6);

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            if (v.clrn_after > 0) begin
                for (int j = 0; j < v.clrn_after; j++) send_bit(1'($urandom_range(0, 1)));
                s_clrn = 1'b0;
                ticks(4);
                s_clrn = 1'b1;
                ticks(4);
                chk_idle("clrn");
            end
            for (int k = 0; k < v.n_ovr; k++) push(1'b0, 64'd0);
            for (int b = v.nbits - 1; b >= 0; b--) send_bit(v.bits[b]);
            chk("cnt_before_en", 64'(bit_cnt), 64'(v.exp_cnt));
            chk("busy_before_en", 64'(busy), 64'd1);
            push(v.exp_valid, v.exp_data);
            en_pulse();
            drain("vec_drain");
            chk_idle("vec_after_en");
        end

        // EN and s_clk edges reach the synchronizer outputs together in FULL.
        send_word(64'h5A5A0F0F12348765);
        chk("coinc_cnt_full", 64'(bit_cnt), 64'd64);
        s_clk = 1'b0;
        sin   = 1'b1;
        ticks(4);
        push(1'b1, 64'h5A5A0F0F12348765);
        s_clk = 1'b1;
        EN    = 1'b1;
        ticks(4);
        EN = 1'b0;
        ticks(4);
        drain("coinc_drain");
        chk_idle("coinc_after");

        // Reset in the middle of a frame, released with s_clk still high.
        for (int j = 0; j < 20; j++) send_bit(1'($urandom_range(0, 1)));
        rst         = 1'b1;
        pdata_model = 64'd0;
        ticks(4);
        chk("rst_mid_pdata", P_Data, 64'd0);
        chk("rst_mid_valid", 64'(valid), 64'd0);
        chk("rst_mid_err", 64'(err), 64'd0);
        chk_idle("rst_mid");
        rst = 1'b0;
        ticks(10);
        chk("rst_sclk_high_cnt", 64'(bit_cnt), 64'd0);
        send_word(64'h0F1E2D3C4B5A6978);
        chk("rst_frame_cnt", 64'(bit_cnt), 64'd64);
        push(1'b1, 64'h0F1E2D3C4B5A6978);
        en_pulse();
        drain("rst_frame_drain");
        chk_idle("rst_frame_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_s2p.md
SEG_S2P -- requirements
Module: seg_s2p

Interface
REQ-001 Parameter DATA_BITS, default 64, SHALL set the frame length in bits.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the flop count of each input synchronizer (minimum 2).
REQ-003 Port clk, input, 1 bit, SHALL be the system clock; single clock domain, all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the reset, synchronous, active-high.
REQ-005 Port s_clk, input, 1 bit, SHALL be the serial shift clock from the serializer; asynchronous to clk.
REQ-006 Port sin, input, 1 bit, SHALL be the serial data line, valid at each s_clk rising edge.
REQ-007 Port EN, input, 1 bit, SHALL be the latch/refresh strobe; its rising edge commits a frame.
REQ-008 Port s_clrn, input, 1 bit, SHALL be the active-low clear from the serializer.
REQ-009 Port P_Data, output, DATA_BITS, SHALL be the last committed parallel frame.
REQ-010 Port valid, output, 1 bit, SHALL be a one-clk pulse on each commit.
REQ-011 Port busy, output, 1 bit, SHALL be high in states SHIFT and FULL.
REQ-012 Port bit_cnt, output, 7 bits, SHALL be the bits received in the current frame, saturating at DATA_BITS.
REQ-013 Port err, output, 1 bit, SHALL be a one-clk pulse on a short frame or an overrun.

Function
REQ-014 s_clk, sin, EN and s_clrn SHALL each pass through a SYNC_STAGES-deep synchronizer, plus one history flop on s_clk and EN for edge detection.
REQ-015 A rising edge SHALL be detected when the synchronized value is 1 and its history is 0; its action SHALL be visible SYNC_STAGES+1 clk edges after the pin transition.
REQ-016 The sin value sampled SHALL be the synchronized sin aligned with the detected s_clk edge (same pipeline depth).
REQ-017 Frames SHALL be MSB first: each s_clk edge shifts the internal register left, with sin entering bit 0.
REQ-018 FSM states SHALL be IDLE (bit_cnt=0), SHIFT (0<bit_cnt<DATA_BITS) and FULL (bit_cnt=DATA_BITS).
REQ-019 On an s_clk edge, IDLE SHALL go to SHIFT, and SHIFT SHALL increment bit_cnt and go to FULL when it reaches DATA_BITS.
REQ-020 On an s_clk edge in FULL, the block SHALL shift (retaining the newest DATA_BITS bits), hold bit_cnt at DATA_BITS, pulse err, and stay in FULL.
REQ-021 On an EN edge in FULL, the block SHALL copy the shift register to P_Data, pulse valid for one clk, clear bit_cnt and go to IDLE.
REQ-022 On an EN edge in IDLE or SHIFT, the block SHALL pulse err, leave P_Data unchanged, clear bit_cnt and go to IDLE.
REQ-023 Synchronized s_clrn=0 SHALL clear the shift register and bit_cnt and force IDLE every cycle it is low; P_Data SHALL be unchanged.
REQ-024 Event priority SHALL be: s_clrn low, then EN edge, then s_clk edge; a lower event in the same cycle SHALL be dropped.
REQ-025 valid and err SHALL never both be high in the same cycle.
REQ-026 P_Data SHALL change only on a commit.

Reset
REQ-027 With rst=1 at a clk edge, the block SHALL clear P_Data, the shift register and bit_cnt, drive valid=0, err=0 and busy=0, enter IDLE, and load all synchronizer and history flops with 0.
REQ-028 With rst=1 mid-frame, the block SHALL discard the partial frame with no valid or err pulse; after release, the first s_clk edge counts as bit 0.
REQ-029 With s_clk high at rst release, no edge SHALL be detected until s_clk goes low and then high again.

Verification
REQ-030 A bench SHALL drive 64 s_clk edges of 0x0123456789ABCDEF then an EN pulse, and SHALL see P_Data=0x0123456789ABCDEF, a single valid pulse, bit_cnt=0 and busy=0.
REQ-031 A bench SHALL drive 40 bits then an EN pulse, and SHALL see one err pulse, P_Data keeping its previous value, and IDLE.
REQ-032 A bench SHALL drive 66 bits then an EN pulse, and SHALL see err on edge 65, bit_cnt stuck at 64, and P_Data equal to the last 64 bits.
REQ-033 A bench SHALL pulse s_clrn low after 30 bits and then send a full 64-bit frame plus EN, and SHALL see P_Data equal to the new frame only.
REQ-034 A bench SHALL make EN and s_clk edges coincide at the synchronizer output when bit_cnt=64, and SHALL see the commit occur with the s_clk edge ignored.
REQ-035 A bench SHALL assert rst at bit 20 and then send a clean frame, and SHALL see no pulses during reset and a correct commit afterwards.
